// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer with a one-word holding register and valid/ready output.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and report it on parity_err.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic accept;
  logic consume;
  logic last_bit;
  logic deliver;

  assign accept  = sin_valid && sin_ready;
  assign consume = dout_valid && dout_ready;
  // clr wins over a final bit arriving in the same cycle
  assign last_bit = accept && !clr && (cnt == CNT_W'(FRAME - 1));
  assign deliver  = last_bit && (!dout_valid || dout_ready);

  // Accumulator with the current bit merged in; with parity the final bit leaves acc untouched.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && (cnt == CNT_W'(i))) begin
        acc_next[i] = sin;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: begin
        if (clr) begin
          state_next = IDLE;
        end else if (last_bit) begin
          state_next = deliver ? IDLE : STALL;
        end else if (accept) begin
          state_next = COLLECT;
        end
      end
      STALL: begin
        if (consume) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sin_ready = (state != STALL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (consume) begin
        dout_valid <= 1'b0;
      end
      if (state == STALL) begin
        // a parked word is never discarded, clr is ignored here
        if (consume) begin
          dout       <= acc;
          dout_valid <= 1'b1;
          acc        <= '0;
        end
      end else if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last_bit) begin
          cnt <= '0;
          if (deliver) begin
            dout       <= acc_next;
            dout_valid <= 1'b1;
            acc        <= '0;
          end else begin
            acc <= acc_next;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
          acc <= acc_next;
        end
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_reg;
  logic stall_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_reg <= 1'b0;
      stall_par  <= 1'b0;
    end else if (state == STALL) begin
      if (consume) begin
        parity_reg <= (^acc) ^ stall_par;
      end
    end else if (deliver) begin
      parity_reg <= (^acc) ^ sin;
    end else if (last_bit) begin
      stall_par <= sin;
    end
  end

  assign parity_err = parity_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=4); parity cases run when SIPO_PARITY_EN is defined.
module tb_sipo_deser;
  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_ready;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             parity_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends frame bits first..last of word w (bit WIDTH is the even-parity bit, optionally flipped).
  task automatic send_bits(input logic [3:0] w, input logic flip, input int first, input int last);
    logic [4:0] frame;
    frame = {(^w) ^ flip, w};
    for (int i = first; i <= last; i++) begin
      sin       = frame[i];
      sin_valid = 1'b1;
      step();
    end
    sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
    total_cnt++; if (dout !== 4'h0) $display("FAIL reset_dout got=%h exp=0", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dout_valid); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", parity_err); else pass_cnt++;
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL reset_sin_ready got=%b exp=1", sin_ready); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    send_bits(4'hD, 1'b0, 0, FLEN - 1);
    total_cnt++; if (dout !== 4'hD) $display("FAIL basic_dout got=%h exp=d", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", dout_valid); else pass_cnt++;
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL basic_sin_ready got=%b exp=1", sin_ready); else pass_cnt++;
    step();
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL basic_one_cycle got=%b exp=0", dout_valid); else pass_cnt++;
    total_cnt++; if (dout !== 4'hD) $display("FAIL basic_dout_hold got=%h exp=d", dout); else pass_cnt++;
    $display("test_basic done: word 0xD");
  endtask

  task automatic test_stall();
    dout_ready = 1'b0;
    send_bits(4'hD, 1'b0, 0, FLEN - 1);
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL stall_first_valid got=%b exp=1", dout_valid); else pass_cnt++;
    send_bits(4'h3, 1'b0, 0, FLEN - 1);
    total_cnt++; if (sin_ready !== 1'b0) $display("FAIL stall_sin_ready got=%b exp=0", sin_ready); else pass_cnt++;
    total_cnt++; if (dout !== 4'hD) $display("FAIL stall_dout_hold got=%h exp=d", dout); else pass_cnt++;
    step();
    total_cnt++; if (sin_ready !== 1'b0) $display("FAIL stall_still got=%b exp=0", sin_ready); else pass_cnt++;
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    total_cnt++; if (dout !== 4'h3) $display("FAIL stall_exit_dout got=%h exp=3", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL stall_exit_valid got=%b exp=1", dout_valid); else pass_cnt++;
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL stall_exit_ready got=%b exp=1", sin_ready); else pass_cnt++;
    dout_ready = 1'b1;
    step();
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", dout_valid); else pass_cnt++;
    $display("test_stall done: 0xD then 0x3");
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b0;
    send_bits(4'hD, 1'b0, 0, FLEN - 1);
    send_bits(4'h6, 1'b0, 0, FLEN - 2);
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL b2b_ready_mid got=%b exp=1", sin_ready); else pass_cnt++;
    dout_ready = 1'b1;
    send_bits(4'h6, 1'b0, FLEN - 1, FLEN - 1);
    total_cnt++; if (dout !== 4'h6) $display("FAIL b2b_dout got=%h exp=6", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", dout_valid); else pass_cnt++;
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL b2b_ready_end got=%b exp=1", sin_ready); else pass_cnt++;
    step();
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", dout_valid); else pass_cnt++;
    $display("test_back_to_back done: 0xD replaced by 0x6");
  endtask

  task automatic test_clr();
    dout_ready = 1'b1;
    send_bits(4'hF, 1'b0, 0, 1);
    clr = 1'b1;
    sin = 1'b1;
    sin_valid = 1'b1;
    step();
    clr = 1'b0;
    sin_valid = 1'b0;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL clr_no_word got=%b exp=0", dout_valid); else pass_cnt++;
    send_bits(4'h6, 1'b0, 0, FLEN - 1);
    total_cnt++; if (dout !== 4'h6) $display("FAIL clr_dout got=%h exp=6", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL clr_valid got=%b exp=1", dout_valid); else pass_cnt++;
    step();
    dout_ready = 1'b0;
    send_bits(4'hA, 1'b0, 0, FLEN - 1);
    send_bits(4'h5, 1'b0, 0, FLEN - 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    total_cnt++; if (sin_ready !== 1'b0) $display("FAIL clr_stall_ready got=%b exp=0", sin_ready); else pass_cnt++;
    total_cnt++; if (dout !== 4'hA) $display("FAIL clr_stall_hold got=%h exp=a", dout); else pass_cnt++;
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    total_cnt++; if (dout !== 4'h5) $display("FAIL clr_stall_dout got=%h exp=5", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL clr_stall_valid got=%b exp=1", dout_valid); else pass_cnt++;
    $display("test_clr done: 0x6 after clr, 0x5 survives clr in stall");
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    send_bits(4'h7, 1'b0, 0, 2);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (dout !== 4'h0) $display("FAIL areset_dout got=%h exp=0", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL areset_valid got=%b exp=0", dout_valid); else pass_cnt++;
    total_cnt++; if (sin_ready !== 1'b1) $display("FAIL areset_ready got=%b exp=1", sin_ready); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL areset_perr got=%b exp=0", parity_err); else pass_cnt++;
    #1;
    reset = 1'b0;
    dout_ready = 1'b1;
    send_bits(4'hF, 1'b0, 0, FLEN - 1);
    total_cnt++; if (dout !== 4'hF) $display("FAIL areset_after got=%h exp=f", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL areset_after_valid got=%b exp=1", dout_valid); else pass_cnt++;
    step();
    $display("test_async_reset done: 0xF after reset");
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    dout_ready = 1'b1;
    send_bits(4'hD, 1'b0, 0, FLEN - 1);
    total_cnt++; if (dout !== 4'hD) $display("FAIL par_ok_dout got=%h exp=d", dout); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL par_ok_perr got=%b exp=0", parity_err); else pass_cnt++;
    step();
    send_bits(4'hD, 1'b1, 0, FLEN - 1);
    total_cnt++; if (dout !== 4'hD) $display("FAIL par_bad_dout got=%h exp=d", dout); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b1) $display("FAIL par_bad_perr got=%b exp=1", parity_err); else pass_cnt++;
    step();
    $display("test_parity done");
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_clr();
    test_async_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule
